mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 17 +
 rtl/read_tag_pipe.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   owner_e        : identifies which requester owns a RAM read in flight.
//   DEF_ADDR_W     : default RAM word-address width.
//   DEF_DATA_W     : default RAM / register word width.
//   DEF_RD_LATENCY : default RAM read latency in cycles (legal range 1..4).
package mem_pkg;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_CONV = 1'b1
  } owner_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_RD_LATENCY = 2;

endpackage

// File: rtl/read_tag_pipe.sv
// Read tag pipe: carries a valid bit and an owner bit alongside each RAM read so
// the returning data can be steered to the requester that issued it.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, empties the pipe
//   valid_i  : a read was granted this cycle
//   owner_i  : owner of that read (mem_pkg::owner_e encoding)
//   valid_o  : a read issued DEPTH cycles ago returns this cycle
//   owner_o  : owner of the returning read
module read_tag_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RD_LATENCY
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] own_q, own_d;

  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = valid_i;
    // Keep idle stages at a known owner so the pipe contents stay clean.
    own_d[0] = valid_i & owner_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign owner_o = own_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one single-port RAM between a register-mapped host
// access path (one command outstanding) and a convolution engine request port.
// Two-way round-robin arbitration, conv first after reset.
// Ports:
//   clk_i, rst_i                      : clock and synchronous active-high reset
//   host_addr_load_i, host_addr_i     : load the host address counter
//   host_wr_i, host_wdata_i           : host write command and data
//   host_rd_i                         : host read command
//   host_addr_o                       : current host address counter
//   host_busy_o                       : host command pending or in flight
//   host_rdata_o                      : last host read word (held)
//   host_drop_o                       : pulse, a host command was ignored
//   mem_done_o                        : pulse, host access completed
//   conv_req_i, conv_we_i, conv_addr_i, conv_wdata_i : conv request (held until granted)
//   conv_gnt_o                        : combinational conv grant
//   conv_rdata_o, conv_rvalid_o       : conv read return
//   ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i : single-port RAM
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Host register path
  input  logic              host_addr_load_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic              host_wr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic              host_rd_i,
  output logic [ADDR_W-1:0] host_addr_o,
  output logic              host_busy_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_drop_o,
  output logic              mem_done_o,
  // Convolution engine port
  input  logic              conv_req_i,
  input  logic              conv_we_i,
  input  logic [ADDR_W-1:0] conv_addr_i,
  input  logic [DATA_W-1:0] conv_wdata_i,
  output logic              conv_gnt_o,
  output logic [DATA_W-1:0] conv_rdata_o,
  output logic              conv_rvalid_o,
  // RAM port
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  // State
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic              pend_q, pend_d;          // host command waiting for a grant
  logic              pend_we_q, pend_we_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic              busy_q, busy_d;          // pending or read in flight
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              drop_q, drop_d;
  owner_e            last_q, last_d;          // owner granted most recently

  // Arbitration and return path
  logic   host_gnt, conv_gnt;
  logic   rd_gnt;
  owner_e rd_owner;
  logic   ret_vld, ret_owner;
  logic   host_ret, conv_ret;
  logic   host_cmd, host_accept;

  // Host wins a contested cycle only if conv was granted last. Nothing is
  // granted during reset so the RAM stays idle.
  assign host_gnt = ~rst_i & pend_q & (~conv_req_i | (last_q == OWNER_CONV));
  assign conv_gnt = ~rst_i & conv_req_i & ~host_gnt;

  assign rd_gnt   = (host_gnt & ~pend_we_q) | (conv_gnt & ~conv_we_i);
  assign rd_owner = host_gnt ? OWNER_HOST : OWNER_CONV;

  read_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_read_tag_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(rd_gnt),
    .owner_i(rd_owner),
    .valid_o(ret_vld),
    .owner_o(ret_owner)
  );

  assign host_ret = ~rst_i & ret_vld & (ret_owner == OWNER_HOST);
  assign conv_ret = ~rst_i & ret_vld & (ret_owner == OWNER_CONV);

  // A host read completes in its return cycle, so busy drops combinationally
  // and a new command may be accepted in that same cycle.
  assign host_busy_o = busy_q & ~host_ret;
  assign host_cmd    = host_wr_i | host_rd_i;
  assign host_accept = host_cmd & ~host_busy_o;

  always_comb begin
    host_addr_d = host_addr_q;
    if (host_gnt) begin
      host_addr_d = host_addr_q + ADDR_W'(1);
    end
    // A load in the same cycle as a command must be seen by that command.
    if (host_addr_load_i) begin
      host_addr_d = host_addr_i;
    end
  end

  always_comb begin
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_wdata_d = pend_wdata_q;
    busy_d       = busy_q;
    if (host_accept) begin
      pend_d       = 1'b1;
      pend_we_d    = host_wr_i;   // write wins when both arrive together
      pend_wdata_d = host_wdata_i;
      busy_d       = 1'b1;
    end else begin
      if (host_gnt) begin
        pend_d = 1'b0;
      end
      if ((host_gnt & pend_we_q) | host_ret) begin
        busy_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_done_d    = host_gnt & pend_we_q;
    drop_d       = (host_cmd & host_busy_o) | (host_wr_i & host_rd_i);
    host_rdata_d = host_ret ? ram_rdata_i : host_rdata_q;
    last_d       = last_q;
    if (host_gnt) begin
      last_d = OWNER_HOST;
    end else if (conv_gnt) begin
      last_d = OWNER_CONV;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      host_addr_q  <= '0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_wdata_q <= '0;
      busy_q       <= 1'b0;
      host_rdata_q <= '0;
      wr_done_q    <= 1'b0;
      drop_q       <= 1'b0;
      last_q       <= OWNER_HOST;  // conv gets the first contested grant
    end else begin
      host_addr_q  <= host_addr_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_wdata_q <= pend_wdata_d;
      busy_q       <= busy_d;
      host_rdata_q <= host_rdata_d;
      wr_done_q    <= wr_done_d;
      drop_q       <= drop_d;
      last_q       <= last_d;
    end
  end

  // RAM port
  assign ram_en_o    = host_gnt | conv_gnt;
  assign ram_we_o    = host_gnt ? pend_we_q : (conv_gnt & conv_we_i);
  assign ram_addr_o  = host_gnt ? host_addr_q : (conv_gnt ? conv_addr_i : '0);
  assign ram_wdata_o = host_gnt ? pend_wdata_q : (conv_gnt ? conv_wdata_i : '0);

  // Outputs
  assign host_addr_o   = host_addr_q;
  assign host_rdata_o  = host_rdata_d;
  assign host_drop_o   = drop_q;
  assign mem_done_o    = wr_done_q | host_ret;
  assign conv_gnt_o    = conv_gnt;
  assign conv_rvalid_o = conv_ret;
  assign conv_rdata_o  = conv_ret ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected RAM accesses,
// host completions and conv returns into queues; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;

  logic          clk_i;
  logic          rst_i;
  logic          host_addr_load_i;
  logic [AW-1:0] host_addr_i;
  logic          host_wr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_rd_i;
  logic [AW-1:0] host_addr_o;
  logic          host_busy_o;
  logic [DW-1:0] host_rdata_o;
  logic          host_drop_o;
  logic          mem_done_o;
  logic          conv_req_i;
  logic          conv_we_i;
  logic [AW-1:0] conv_addr_i;
  logic [DW-1:0] conv_wdata_i;
  logic          conv_gnt_o;
  logic [DW-1:0] conv_rdata_o;
  logic          conv_rvalid_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .host_addr_load_i(host_addr_load_i),
    .host_addr_i     (host_addr_i),
    .host_wr_i       (host_wr_i),
    .host_wdata_i    (host_wdata_i),
    .host_rd_i       (host_rd_i),
    .host_addr_o     (host_addr_o),
    .host_busy_o     (host_busy_o),
    .host_rdata_o    (host_rdata_o),
    .host_drop_o     (host_drop_o),
    .mem_done_o      (mem_done_o),
    .conv_req_i      (conv_req_i),
    .conv_we_i       (conv_we_i),
    .conv_addr_i     (conv_addr_i),
    .conv_wdata_i    (conv_wdata_i),
    .conv_gnt_o      (conv_gnt_o),
    .conv_rdata_o    (conv_rdata_o),
    .conv_rvalid_o   (conv_rvalid_o),
    .ram_en_o        (ram_en_o),
    .ram_we_o        (ram_we_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wdata_o     (ram_wdata_o),
    .ram_rdata_i     (ram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- RAM model (4096 words, address bits [11:0]) --------------
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] rd_pipe [LAT];

  initial begin
    foreach (mem[i]) mem[i] = '0;
    foreach (rd_pipe[i]) rd_pipe[i] = '0;
  end

  always @(posedge clk_i) begin
    if (ram_en_o && ram_we_o) mem[ram_addr_o[11:0]] <= ram_wdata_o;
    rd_pipe[0] <= (ram_en_o && !ram_we_o) ? mem[ram_addr_o[11:0]] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata_i = rd_pipe[LAT-1];

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // ---------------- Scoreboard ------------------------------------------------
  typedef struct packed {
    logic          conv;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_exp_t;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } done_exp_t;

  ram_exp_t      ram_q [$];
  done_exp_t     done_q [$];
  logic [DW-1:0] conv_q [$];

  int check_cnt = 0;
  int fail_cnt  = 0;
  int exp_drops = 0;
  int seen_drops = 0;
  int host_rd_gnt_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    ram_exp_t  e;
    done_exp_t d;
    logic [DW-1:0] c;
    if (ram_en_o) begin
      if (ram_q.size() == 0) begin
        chk("ram_unexpected_access", {32'h0, ram_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = ram_q.pop_front();
        chk("ram_access", {14'h0, conv_gnt_o, ram_we_o, ram_addr_o, ram_we_o ? ram_wdata_o : 16'h0},
            {14'h0, e.conv, e.we, e.addr, e.we ? e.wdata : 16'h0});
        if (!e.conv && !e.we) host_rd_gnt_cyc = cyc_cnt;
      end
    end
    if (conv_rvalid_o) begin
      if (conv_q.size() == 0) begin
        chk("conv_unexpected_rvalid", 64'(conv_rdata_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        c = conv_q.pop_front();
        chk("conv_rdata", 64'(conv_rdata_o), 64'(c));
      end
    end
    if (mem_done_o) begin
      if (done_q.size() == 0) begin
        chk("unexpected_mem_done", 64'(1), 64'(0));
      end else begin
        d = done_q.pop_front();
        chk("busy_at_done", 64'(host_busy_o), 64'(0));
        if (d.rd) begin
          chk("host_rdata", 64'(host_rdata_o), 64'(d.data));
          chk("host_rd_latency", 64'(cyc_cnt - host_rd_gnt_cyc), 64'(LAT));
        end
      end
    end
    if (host_drop_o) seen_drops++;
  end

  // ---------------- Stimulus helpers -----------------------------------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_cmd(input logic ld, input logic [AW-1:0] a, input logic wr,
                          input logic rd, input logic [DW-1:0] d);
    host_addr_load_i = ld;
    host_addr_i      = a;
    host_wr_i        = wr;
    host_rd_i        = rd;
    host_wdata_i     = d;
    cyc();
    host_addr_load_i = 1'b0;
    host_wr_i        = 1'b0;
    host_rd_i        = 1'b0;
  endtask

  task automatic conv_run(input int n, input logic we, input logic [AW-1:0] base_a,
                          input logic [DW-1:0] base_d);
    logic g;
    int   t;
    for (int i = 0; i < n; i++) begin
      conv_req_i   = 1'b1;
      conv_we_i    = we;
      conv_addr_i  = base_a + AW'(i);
      conv_wdata_i = base_d + DW'(i);
      g = 1'b0;
      t = 0;
      while (!g && t < 20) begin
        @(negedge clk_i);
        g = conv_gnt_o;
        cyc();
        t++;
      end
      chk("conv_grant_wait", 64'(g), 64'(1));
    end
    conv_req_i = 1'b0;
    conv_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed sequence ----------------------------------------
  initial begin
    rst_i = 1'b1;
    host_addr_load_i = 1'b0; host_addr_i = '0; host_wr_i = 1'b0; host_rd_i = 1'b0;
    host_wdata_i = '0; conv_req_i = 1'b0; conv_we_i = 1'b0; conv_addr_i = '0;
    conv_wdata_i = '0;
    repeat (3) cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_host_addr", 64'(host_addr_o), 64'(0));
    chk("rst_busy", 64'(host_busy_o), 64'(0));
    chk("rst_rdata", 64'(host_rdata_o), 64'(0));
    chk("rst_done", 64'(mem_done_o), 64'(0));
    chk("rst_drop", 64'(host_drop_o), 64'(0));
    chk("rst_ram_en", 64'(ram_en_o), 64'(0));
    chk("rst_rvalid", 64'(conv_rvalid_o), 64'(0));

    // Host write 0xBEEF at 0x10
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'h10, wdata: 16'hBEEF});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    cyc();
    host_cmd(1'b1, 32'h10, 1'b1, 1'b0, 16'hBEEF);
    @(negedge clk_i);
    chk("busy_while_pending", 64'(host_busy_o), 64'(1));
    cyc();
    @(negedge clk_i);
    chk("wr_addr_inc", 64'(host_addr_o), 64'h11);
    chk("wr_busy_fall", 64'(host_busy_o), 64'(0));
    repeat (2) cyc();

    // Host read at 0x10, return LAT cycles after grant
    ram_q.push_back('{conv: 1'b0, we: 1'b0, addr: 32'h10, wdata: 16'h0});
    done_q.push_back('{rd: 1'b1, data: 16'hBEEF});
    host_cmd(1'b1, 32'h10, 1'b0, 1'b1, 16'h0);
    repeat (5) cyc();
    @(negedge clk_i);
    chk("rd_rdata_held", 64'(host_rdata_o), 64'hBEEF);
    chk("rd_addr_inc", 64'(host_addr_o), 64'h11);

    // Continuous conv writes with two host writes: alternating grants
    cyc();
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h100, wdata: 16'h1000});
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h101, wdata: 16'h1001});
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'h200, wdata: 16'h1111});
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h102, wdata: 16'h1002});
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'h201, wdata: 16'h2222});
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h103, wdata: 16'h1003});
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h104, wdata: 16'h1004});
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h105, wdata: 16'h1005});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    fork
      conv_run(6, 1'b1, 32'h100, 16'h1000);
      begin
        cyc();
        host_cmd(1'b1, 32'h200, 1'b1, 1'b0, 16'h1111);
        cyc();
        host_cmd(1'b0, 32'h0, 1'b1, 1'b0, 16'h2222);
      end
    join
    repeat (4) cyc();
    @(negedge clk_i);
    chk("alt_addr", 64'(host_addr_o), 64'h202);

    // Write at 0xFFFF_FFFF wraps the counter; read while busy is dropped
    cyc();
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'hFFFF_FFFF, wdata: 16'hCAFE});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    exp_drops++;
    host_cmd(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'hCAFE);
    host_cmd(1'b0, 32'h0, 1'b0, 1'b1, 16'h0);
    @(negedge clk_i);
    chk("drop_while_busy", 64'(host_drop_o), 64'(1));
    chk("addr_wrap", 64'(host_addr_o), 64'(0));
    repeat (3) cyc();

    // Write and read together: write wins, read dropped
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'h40, wdata: 16'h4444});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    exp_drops++;
    host_cmd(1'b1, 32'h40, 1'b1, 1'b1, 16'h4444);
    @(negedge clk_i);
    chk("drop_wr_rd", 64'(host_drop_o), 64'(1));
    repeat (4) cyc();
    @(negedge clk_i);
    chk("wr_rd_addr", 64'(host_addr_o), 64'h41);

    // Interleaved conv and host reads, returns routed in grant order
    cyc();
    ram_q.push_back('{conv: 1'b1, we: 1'b0, addr: 32'h100, wdata: 16'h0});
    ram_q.push_back('{conv: 1'b1, we: 1'b0, addr: 32'h101, wdata: 16'h0});
    ram_q.push_back('{conv: 1'b0, we: 1'b0, addr: 32'h200, wdata: 16'h0});
    ram_q.push_back('{conv: 1'b1, we: 1'b0, addr: 32'h102, wdata: 16'h0});
    conv_q.push_back(16'h1000);
    conv_q.push_back(16'h1001);
    conv_q.push_back(16'h1002);
    done_q.push_back('{rd: 1'b1, data: 16'h1111});
    fork
      conv_run(3, 1'b0, 32'h100, 16'h0);
      begin
        cyc();
        host_cmd(1'b1, 32'h200, 1'b0, 1'b1, 16'h0);
      end
    join
    repeat (6) cyc();
    @(negedge clk_i);
    chk("mix_rdata", 64'(host_rdata_o), 64'h1111);
    chk("mix_addr", 64'(host_addr_o), 64'h201);

    // Reset with a conv read and a host read in flight: both discarded
    cyc();
    ram_q.push_back('{conv: 1'b1, we: 1'b0, addr: 32'h100, wdata: 16'h0});
    ram_q.push_back('{conv: 1'b0, we: 1'b0, addr: 32'h10, wdata: 16'h0});
    conv_req_i = 1'b1; conv_we_i = 1'b0; conv_addr_i = 32'h100;
    host_addr_load_i = 1'b1; host_addr_i = 32'h10; host_rd_i = 1'b1;
    cyc();
    conv_req_i = 1'b0;
    host_addr_load_i = 1'b0; host_rd_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst2_host_addr", 64'(host_addr_o), 64'(0));
    chk("rst2_rdata", 64'(host_rdata_o), 64'(0));
    chk("rst2_busy", 64'(host_busy_o), 64'(0));
    chk("rst2_done", 64'(mem_done_o), 64'(0));
    chk("rst2_rvalid", 64'(conv_rvalid_o), 64'(0));
    chk("rst2_ram_en", 64'(ram_en_o), 64'(0));
    repeat (6) cyc();

    // After reset conv wins the first contested cycle
    ram_q.push_back('{conv: 1'b1, we: 1'b1, addr: 32'h300, wdata: 16'h3333});
    ram_q.push_back('{conv: 1'b0, we: 1'b1, addr: 32'h0, wdata: 16'h5555});
    done_q.push_back('{rd: 1'b0, data: 16'h0});
    fork
      host_cmd(1'b0, 32'h0, 1'b1, 1'b0, 16'h5555);
      begin
        cyc();
        conv_run(1, 1'b1, 32'h300, 16'h3333);
      end
    join
    repeat (5) cyc();
    @(negedge clk_i);
    chk("post_rst_addr", 64'(host_addr_o), 64'h1);

    chk("ram_q_empty", 64'(ram_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    chk("conv_q_empty", 64'(conv_q.size()), 64'(0));
    chk("drop_count", 64'(seen_drops), 64'(exp_drops));

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
